// File: rtl/systolic_array_arbiter.sv
// Round-robin arbiter/sequencer sharing one 8x8 systolic engine between
// two requesters: grants jobs, issues start, routes A/B/C streams.
module systolic_array_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int TIMEOUT    = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   req_start,
    output logic [1:0]                   req_ready,
    output logic [1:0]                   req_done,
    input  logic [1:0]                   req_a_valid,
    output logic [1:0]                   req_a_ready,
    input  logic signed [DATA_WIDTH-1:0] req_a_in [2][8],
    input  logic [1:0]                   req_b_valid,
    output logic [1:0]                   req_b_ready,
    input  logic signed [DATA_WIDTH-1:0] req_b_in [2][8],
    output logic [1:0]                   req_c_valid,
    input  logic [1:0]                   req_c_ready,
    output logic signed [ACC_WIDTH-1:0]  req_c_out [8],
    output logic                         eng_start,
    input  logic                         eng_ready,
    input  logic                         eng_done,
    output logic                         eng_a_valid,
    input  logic                         eng_a_ready,
    output logic signed [DATA_WIDTH-1:0] eng_a_in [8],
    output logic                         eng_b_valid,
    input  logic                         eng_b_ready,
    output logic signed [DATA_WIDTH-1:0] eng_b_in [8],
    input  logic                         eng_c_valid,
    output logic                         eng_c_ready,
    input  logic signed [ACC_WIDTH-1:0]  eng_c_out [8],
    output logic                         owner,
    output logic                         busy,
    output logic [1:0]                   err,
    output logic [15:0]                  jobs_done [2]
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    localparam int WDW = $clog2(TIMEOUT) + 1;
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT - 1);
    localparam logic [WDW-1:0] WD_SET = WDW'(TIMEOUT - 2);

    logic [1:0]     state;
    logic           last_grant;
    logic [WDW-1:0] wd;
    logic           cand;
    logic           grant_ok;
    logic           accept;
    logic           in_run;
    logic [1:0]     sel;

    // Tie goes to whoever was not served last
    assign cand     = req_start[1] & (~req_start[0] | ~last_grant);
    assign grant_ok = (state == IDLE) & (|req_start) & eng_ready;
    assign req_ready = grant_ok ? (cand ? 2'b10 : 2'b01) : 2'b00;
    assign accept   = |(req_ready & req_start);

    assign in_run = (state == RUN);
    assign sel    = owner ? 2'b10 : 2'b01;
    assign busy   = (state != IDLE);

    assign eng_a_valid = in_run & req_a_valid[owner];
    assign eng_b_valid = in_run & req_b_valid[owner];
    assign eng_a_in    = req_a_in[owner];
    assign eng_b_in    = req_b_in[owner];
    assign req_a_ready = (in_run & eng_a_ready) ? sel : 2'b00;
    assign req_b_ready = (in_run & eng_b_ready) ? sel : 2'b00;
    assign req_c_valid = (in_run & eng_c_valid) ? sel : 2'b00;
    assign eng_c_ready = in_run & req_c_ready[owner];
    assign req_c_out   = eng_c_out;
    assign req_done    = (in_run & eng_done) ? sel : 2'b00;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            eng_start    <= 1'b0;
            err          <= 2'b00;
            wd           <= '0;
            jobs_done[0] <= '0;
            jobs_done[1] <= '0;
        end else begin
            eng_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        owner     <= cand;
                        eng_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd    <= '0;
                    state <= RUN;
                end
                RUN: begin
                    if (eng_done) begin
                        jobs_done[owner] <= jobs_done[owner] + 16'd1;
                        last_grant       <= owner;
                        state            <= IDLE;
                    end else begin
                        // Counter saturates; error latches as it hits the limit
                        if (wd != WD_MAX) wd <= wd + WDW'(1);
                        if (wd >= WD_SET) err[owner] <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_array_arbiter.sv
// Randomized self-checking bench for systolic_array_arbiter with a
// job-level reference model (grant order, counters, error flags).
module tb_systolic_array_arbiter;

    localparam int DW = 8;
    localparam int AW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [1:0] req_start, req_ready, req_done;
    logic [1:0] req_a_valid, req_a_ready, req_b_valid, req_b_ready;
    logic [1:0] req_c_valid, req_c_ready, err;
    logic signed [DW-1:0] req_a_in [2][8];
    logic signed [DW-1:0] req_b_in [2][8];
    logic signed [DW-1:0] eng_a_in [8];
    logic signed [DW-1:0] eng_b_in [8];
    logic signed [AW-1:0] req_c_out [8];
    logic signed [AW-1:0] eng_c_out [8];
    logic eng_start, eng_ready, eng_done;
    logic eng_a_valid, eng_a_ready, eng_b_valid, eng_b_ready;
    logic eng_c_valid, eng_c_ready, owner, busy;
    logic [15:0] jobs_done [2];

    systolic_array_arbiter #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_start(req_start), .req_ready(req_ready), .req_done(req_done),
        .req_a_valid(req_a_valid), .req_a_ready(req_a_ready), .req_a_in(req_a_in),
        .req_b_valid(req_b_valid), .req_b_ready(req_b_ready), .req_b_in(req_b_in),
        .req_c_valid(req_c_valid), .req_c_ready(req_c_ready), .req_c_out(req_c_out),
        .eng_start(eng_start), .eng_ready(eng_ready), .eng_done(eng_done),
        .eng_a_valid(eng_a_valid), .eng_a_ready(eng_a_ready), .eng_a_in(eng_a_in),
        .eng_b_valid(eng_b_valid), .eng_b_ready(eng_b_ready), .eng_b_in(eng_b_in),
        .eng_c_valid(eng_c_valid), .eng_c_ready(eng_c_ready), .eng_c_out(eng_c_out),
        .owner(owner), .busy(busy), .err(err), .jobs_done(jobs_done)
    );

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model: job counts, who was served last, sticky errors
    int         m_jobs [2];
    logic       m_last;
    logic [1:0] m_err;

    function automatic logic [1:0] oh(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_streams();
        req_a_valid = 0; req_b_valid = 0; req_c_ready = 0;
        eng_a_ready = 0; eng_b_ready = 0; eng_c_valid = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        m_jobs[0] = 0; m_jobs[1] = 0; m_last = 1'b1; m_err = 2'b00;
    endtask

    task automatic start_job(input logic [1:0] starts, output logic w);
        w = (starts == 2'b11) ? ~m_last : starts[1];
        req_start = starts; eng_ready = 1'b1;
        #1;
        n_tot++; if (req_ready !== oh(w)) $display("FAIL grant: got %b want %b", req_ready, oh(w)); else n_pass++;
        step();
        req_start = 2'b00;
        req_a_valid = 2'b11; req_b_valid = 2'b11; req_c_ready = 2'b11;
        eng_a_ready = 1; eng_b_ready = 1; eng_c_valid = 1;
        #1;
        n_tot++; if ({eng_start, busy, owner} !== {2'b11, w}) $display("FAIL issue: got %b want %b", {eng_start, busy, owner}, {2'b11, w}); else n_pass++;
        n_tot++; if ({eng_a_valid, eng_b_valid, req_a_ready, req_b_ready, req_c_valid, eng_c_ready} !== 9'd0)
            $display("FAIL issue_quiet: got %b want 0", {eng_a_valid, eng_b_valid, req_a_ready, req_b_ready, req_c_valid, eng_c_ready});
        else n_pass++;
        clear_streams();
        step();
        n_tot++; if ({eng_start, busy} !== 2'b01) $display("FAIL run_entry: got %b want 01", {eng_start, busy}); else n_pass++;
    endtask

    task automatic route_cycle(input logic w, input bit cfull);
        bit bad;
        req_a_valid = 2'($urandom); req_b_valid = 2'($urandom);
        req_c_ready = cfull ? 2'b11 : 2'($urandom);
        eng_a_ready = 1'($urandom); eng_b_ready = 1'($urandom);
        eng_c_valid = cfull ? 1'b1 : 1'($urandom);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 8; j++) begin
                req_a_in[i][j] = DW'($urandom);
                req_b_in[i][j] = DW'($urandom);
            end
        for (int j = 0; j < 8; j++) eng_c_out[j] = $urandom;
        #1;
        n_tot++; if ({eng_a_valid, eng_b_valid} !== {req_a_valid[w], req_b_valid[w]})
            $display("FAIL route_valid: got %b want %b", {eng_a_valid, eng_b_valid}, {req_a_valid[w], req_b_valid[w]});
        else n_pass++;
        bad = 0;
        for (int j = 0; j < 8; j++)
            if (eng_a_in[j] !== req_a_in[w][j] || eng_b_in[j] !== req_b_in[w][j] || req_c_out[j] !== eng_c_out[j]) bad = 1;
        n_tot++; if (bad) $display("FAIL route_data: got mismatch want owner %0d data", w); else n_pass++;
        n_tot++; if ({req_a_ready, req_b_ready} !== {(eng_a_ready ? oh(w) : 2'b00), (eng_b_ready ? oh(w) : 2'b00)})
            $display("FAIL route_ready: got %b owner %0d", {req_a_ready, req_b_ready}, w);
        else n_pass++;
        n_tot++; if ({req_c_valid, eng_c_ready} !== {(eng_c_valid ? oh(w) : 2'b00), req_c_ready[w]})
            $display("FAIL route_c: got %b want %b", {req_c_valid, eng_c_ready}, {(eng_c_valid ? oh(w) : 2'b00), req_c_ready[w]});
        else n_pass++;
    endtask

    task automatic finish_job(input logic w);
        clear_streams();
        eng_done = 1'b1;
        #1;
        n_tot++; if (req_done !== oh(w)) $display("FAIL done_pulse: got %b want %b", req_done, oh(w)); else n_pass++;
        step();
        eng_done = 1'b0;
        m_jobs[w] = (m_jobs[w] + 1) % 65536;
        m_last = w;
        #1;
        n_tot++; if (jobs_done[w] !== 16'(m_jobs[w])) $display("FAIL jobs_done%0d: got %0d want %0d", w, jobs_done[w], m_jobs[w]); else n_pass++;
        n_tot++; if ({busy, req_done, err} !== {3'b000, m_err}) $display("FAIL post_done: got %b want %b", {busy, req_done, err}, {3'b000, m_err}); else n_pass++;
    endtask

    task automatic test_reset();
        req_start = 0; eng_ready = 0; eng_done = 0;
        clear_streams();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 8; j++) begin
                req_a_in[i][j] = 0; req_b_in[i][j] = 0;
            end
        for (int j = 0; j < 8; j++) eng_c_out[j] = 0;
        do_reset();
        #1;
        n_tot++; if ({busy, owner, eng_start, err, req_ready, req_done} !== 9'd0)
            $display("FAIL reset_ctrl: got %b want 0", {busy, owner, eng_start, err, req_ready, req_done});
        else n_pass++;
        n_tot++; if ({jobs_done[0], jobs_done[1]} !== 32'd0) $display("FAIL reset_jobs: got %h want 0", {jobs_done[0], jobs_done[1]}); else n_pass++;
    endtask

    task automatic test_single_job();
        logic w;
        int c0, c1;
        c0 = 0; c1 = 0;
        start_job(2'b01, w);
        for (int k = 0; k < 8; k++) begin
            route_cycle(w, 1'b1);
            c0 += int'(req_c_valid[0] & req_c_ready[0]);
            c1 += int'(req_c_valid[1]);
            step();
        end
        n_tot++; if (c0 !== 8 || c1 !== 0) $display("FAIL c_rows: got %0d/%0d want 8/0", c0, c1); else n_pass++;
        finish_job(w);
    endtask

    task automatic test_tie();
        logic w;
        logic [3:0] seq;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            start_job(2'b11, w);
            seq[k] = w;
            route_cycle(w, 1'b0);
            step();
            finish_job(w);
        end
        n_tot++; if (seq !== 4'b1010) $display("FAIL tie_order: got %b want 1010", seq); else n_pass++;
        n_tot++; if ({jobs_done[0], jobs_done[1]} !== {16'd2, 16'd2}) $display("FAIL tie_counts: got %0d,%0d want 2,2", jobs_done[0], jobs_done[1]); else n_pass++;
    endtask

    task automatic test_isolation();
        logic w;
        start_job(2'b10, w);
        for (int j = 0; j < 8; j++) begin
            req_a_in[0][j] = DW'($urandom); req_a_in[1][j] = DW'($urandom);
        end
        req_a_valid = 2'b01; req_c_ready = 2'b01; eng_a_ready = 1; eng_c_valid = 1;
        #1;
        n_tot++; if ({req_a_ready[0], req_c_valid[0], eng_a_valid, eng_c_ready} !== 4'b0000)
            $display("FAIL isolate: got %b want 0000", {req_a_ready[0], req_c_valid[0], eng_a_valid, eng_c_ready});
        else n_pass++;
        n_tot++; if (eng_a_in[3] !== req_a_in[1][3]) $display("FAIL isolate_data: got %h want %h", eng_a_in[3], req_a_in[1][3]); else n_pass++;
        step();
        route_cycle(w, 1'b0);
        step();
        finish_job(w);
    endtask

    task automatic test_back_to_back();
        logic w;
        start_job(2'b01, w);
        route_cycle(w, 1'b0);
        step();
        clear_streams();
        req_start = 2'b10; eng_done = 1'b1;
        #1;
        n_tot++; if ({req_ready, req_done} !== 4'b0001) $display("FAIL b2b_done: got %b want 0001", {req_ready, req_done}); else n_pass++;
        step();
        eng_done = 1'b0;
        m_jobs[0] = m_jobs[0] + 1; m_last = 1'b0;
        #1;
        n_tot++; if ({busy, req_ready} !== 3'b010) $display("FAIL b2b_idle: got %b want 010", {busy, req_ready}); else n_pass++;
        step();
        req_start = 2'b00;
        #1;
        n_tot++; if ({eng_start, owner} !== 2'b11) $display("FAIL b2b_start: got %b want 11", {eng_start, owner}); else n_pass++;
        step();
        route_cycle(1'b1, 1'b0);
        step();
        finish_job(1'b1);
    endtask

    task automatic test_watchdog();
        logic w;
        start_job(2'($urandom_range(1, 3)), w);
        repeat (14) step();
        n_tot++; if (err !== m_err) $display("FAIL wd_early: got %b want %b", err, m_err); else n_pass++;
        step();
        m_err[w] = 1'b1;
        n_tot++; if ({err, busy} !== {m_err, 1'b1}) $display("FAIL wd_flag: got %b want %b", {err, busy}, {m_err, 1'b1}); else n_pass++;
        repeat (5) step();
        finish_job(w);
    endtask

    task automatic test_reset_mid_run();
        logic w;
        start_job(2'b01, w);
        route_cycle(w, 1'b1);
        req_a_valid = 2'b11; req_b_valid = 2'b11; req_c_ready = 2'b11;
        eng_a_ready = 1; eng_b_ready = 1; eng_c_valid = 1;
        do_reset();
        #1;
        n_tot++; if ({busy, owner, eng_start, err} !== 5'd0) $display("FAIL rst_run_ctrl: got %b want 0", {busy, owner, eng_start, err}); else n_pass++;
        n_tot++; if ({jobs_done[0], jobs_done[1]} !== 32'd0) $display("FAIL rst_run_jobs: got %h want 0", {jobs_done[0], jobs_done[1]}); else n_pass++;
        n_tot++; if ({eng_a_valid, eng_b_valid, req_a_ready, req_b_ready, req_c_valid, eng_c_ready} !== 9'd0)
            $display("FAIL rst_run_streams: got %b want 0", {eng_a_valid, eng_b_valid, req_a_ready, req_b_ready, req_c_valid, eng_c_ready});
        else n_pass++;
        clear_streams();
    endtask

    task automatic test_random();
        logic w;
        logic [1:0] s;
        for (int k = 0; k < 16; k++) begin
            s = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) begin
                req_start = s; eng_ready = 1'b0;
                #1;
                n_tot++; if (req_ready !== 2'b00) $display("FAIL no_eng_ready: got %b want 00", req_ready); else n_pass++;
                step();
                n_tot++; if (busy !== 1'b0) $display("FAIL held_idle: got %b want 0", busy); else n_pass++;
            end
            if ($urandom_range(0, 3) == 0) begin
                req_start = 2'b00; eng_done = 1'b1;
                #1;
                n_tot++; if (req_done !== 2'b00) $display("FAIL stray_done: got %b want 00", req_done); else n_pass++;
                step();
                eng_done = 1'b0;
                #1;
                n_tot++; if ({jobs_done[0], jobs_done[1]} !== {16'(m_jobs[0]), 16'(m_jobs[1])})
                    $display("FAIL stray_count: got %0d,%0d want %0d,%0d", jobs_done[0], jobs_done[1], m_jobs[0], m_jobs[1]);
                else n_pass++;
            end
            start_job(s, w);
            repeat ($urandom_range(1, 10)) begin
                route_cycle(w, 1'b0);
                step();
            end
            finish_job(w);
        end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_tie();
        test_isolation();
        test_back_to_back();
        test_random();
        test_watchdog();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/systolic_array_arbiter.md
# systolic_array_arbiter

Round-robin arbiter and sequencer that shares one 8x8 systolic matrix-multiply engine between two requesters. It grants the engine to one requester per job and issues the engine start pulse. It routes that requester's A/B input streams into the engine and its C result stream back out, and reports per-requester job completion. It sits between two client buffers/DMA ports and the engine's start/done/ready and a/b/c valid-ready ports.

## Interface
Parameters:
- DATA_WIDTH, 8, A/B element width (signed)
- ACC_WIDTH, 32, C element width (signed)
- TIMEOUT, 4096, RUN-state cycle limit before the watchdog flags an error

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- req_start[2]  in  1 each  requester job request (held until accepted)
- req_ready[2]  out  1 each  grant; job accepted when req_start[i] & req_ready[i]
- req_done[2]  out  1 each  one-cycle job-complete pulse
- req_a_valid[2] / req_a_ready[2] / req_a_in[2][8]  in/out/in  1/1/DATA_WIDTH  per-requester A row stream
- req_b_valid[2] / req_b_ready[2] / req_b_in[2][8]  in/out/in  1/1/DATA_WIDTH  per-requester B column stream
- req_c_valid[2] / req_c_ready[2]  out/in  1 each  per-requester C row handshake
- req_c_out[8]  out  ACC_WIDTH  C row, broadcast to both requesters
- eng_start  out  1  engine start pulse
- eng_ready / eng_done  in  1  engine idle indication / completion pulse
- eng_a_valid, eng_a_ready, eng_a_in[8]; eng_b_valid, eng_b_ready, eng_b_in[8]  engine input streams
- eng_c_valid, eng_c_ready, eng_c_out[8]  engine output stream
- owner  out  1  requester currently granted
- busy  out  1  high in ISSUE or RUN
- err[2]  out  1 each  sticky watchdog error, per requester
- jobs_done[2]  out  16 each  completed-job counters

## Operation
- States: IDLE, ISSUE, RUN.
- Transitions from IDLE:
  - Candidate is the requester with req_start high. If both are high, the candidate is the one not equal to last_grant.
  - req_ready[candidate] = eng_ready while in IDLE. All other req_ready are 0.
  - On acceptance: owner <= candidate, eng_start <= 1 (registered), go to ISSUE.
- ISSUE: lasts exactly one cycle. eng_start is high during ISSUE only. Next state is RUN.
- RUN, stream routing (combinational):
  - eng_a/b valid and data come from the owner.
  - req_a/b_ready[owner] = eng_a/b_ready.
  - req_c_valid[owner] = eng_c_valid.
  - eng_c_ready = req_c_ready[owner].
  - The non-owner's ready and c_valid signals are 0.
- Outside RUN, all stream valid and ready outputs are 0. req_c_out always equals eng_c_out.
- RUN completion, on eng_done:
  - req_done[owner] = 1 in the same cycle (combinational).
  - jobs_done[owner] increments and wraps from 0xFFFF to 0.
  - last_grant <= owner; go to IDLE.
- Watchdog:
  - A counter clears on entry to RUN and increments each RUN cycle.
  - When it reaches TIMEOUT-1 without eng_done, err[owner] <= 1 (sticky until reset).
  - The state remains RUN and the counter saturates.
- Reset (rst=0 at an edge, including mid-job):
  - state IDLE, owner 0, last_grant 1 (requester 0 wins the first tie).
  - eng_start 0, err 0, jobs_done 0, watchdog counter 0.
  - The arbiter does not reset the engine.

## Timing
- Reset values of all outputs:
  - req_ready = 0 unless the IDLE grant condition holds in the first post-reset cycle.
  - req_done 0, stream valids and readies 0, eng_start 0.
  - owner 0, busy 0, err 0, jobs_done 0.
- Start latency: the accept edge is cycle N. eng_start is high in cycle N+1 (ISSUE). Routing is active from cycle N+2 (RUN).
- eng_done at cycle M: req_done is high in cycle M, IDLE in M+1. The earliest next accept is at edge M+1, with eng_start in M+2.
- A req_start arriving in the same cycle as eng_done is not granted before IDLE.
- req_start without eng_ready: no grant. The request must hold.
- eng_done outside RUN is ignored: no req_done and no counter change.
- Round-robin guarantee: under continuous requests from both requesters, grants alternate 0,1,0,1.

## Test plan
- Single job: req_start[0]=1 with eng_ready=1.
  - Expect req_ready[0]=1 at accept, eng_start high for exactly 1 cycle, owner=0.
  - A/B beats pass to the engine; 8 C rows reach requester 0 only.
  - eng_done -> req_done[0] pulse, jobs_done[0]=1.
- Tie after reset: both req_start high.
  - Expect grants 0,1,0,1 over 4 jobs; jobs_done = {2,2}.
- Isolation: during an owner=1 job, drive req_a_valid[0]=1 and req_c_ready[0]=1.
  - Expect req_a_ready[0]=0 and req_c_valid[0]=0.
  - Engine data equals requester 1 data.
- Back-to-back: req_start[1] rises in the eng_done cycle of a requester-0 job.
  - Expect IDLE next cycle, accept one cycle later, eng_start two cycles after done.
- Watchdog: TIMEOUT=16, eng_done withheld.
  - Expect err[owner]=1 after 15 RUN cycles, still busy.
  - A later eng_done still gives req_done, and err stays 1.
- Reset mid-RUN: rst=0 for 1 cycle.
  - Expect IDLE, busy 0, counters 0, err 0, and all stream valid/ready outputs 0 on the next cycle.
